// File: rtl/restoring_divider_param_if.sv
// Divider request/result bundle shared by the issuing logic and the divider.
// Latency: none (wires only).
// Backpressure: the issuer holds off while busy is high; start is only sampled in IDLE.
interface restoring_divider_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/restoring_divider_param.sv
// Multi-cycle restoring divider with signed/unsigned mode, divide-by-zero and overflow flags.
// Latency: WIDTH+3 clocks start->done (2 clocks on divide by zero); one op in flight.
// Backpressure: busy is high outside IDLE; start is ignored until the divider is back in IDLE.
module restoring_divider_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    rst,
  restoring_divider_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
    logic             ovf;
  } res_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // Operands and mode captured on the accepting edge; the bus may change afterwards.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             mode_q;

  // Partial remainder never reaches 2^WIDTH once restored, so only the shifted
  // working value needs the extra bit.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  res_t             res_q;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   t_diff;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic             neg_dvd;
  logic             neg_dvs;
  res_t             fix_res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? (~x + ONE) : x;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: state_d = (dvs_q == '0) ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  // One restoring step: shift {A,Q} left, trial-subtract M, keep or restore.
  always_comb begin
    a_sh   = {a_q, q_q[WIDTH-1]};
    q_sh   = {q_q[WIDTH-2:0], 1'b0};
    t_diff = a_sh - {1'b0, m_q};
    if (t_diff[WIDTH]) begin
      a_next = a_sh[WIDTH-1:0];
      q_next = q_sh;
    end else begin
      a_next = t_diff[WIDTH-1:0];
      q_next = q_sh | ONE;
    end
  end

  // Sign fix-up of the magnitude result; remainder follows the dividend's sign.
  always_comb begin
    neg_dvd     = mode_q & dvd_q[WIDTH-1];
    neg_dvs     = mode_q & dvs_q[WIDTH-1];
    fix_res.quo = (neg_dvd ^ neg_dvs) ? (~q_q + ONE) : q_q;
    fix_res.rem = neg_dvd ? (~a_q + ONE) : a_q;
    fix_res.dbz = 1'b0;
    fix_res.ovf = mode_q && (dvd_q == MOST_NEG) && (dvs_q == '1);
  end

  // Operand capture, iteration datapath, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      mode_q <= 1'b0;
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dvd_q  <= bus.dividend;
            dvs_q  <= bus.divisor;
            mode_q <= bus.signed_mode;
          end
        end
        S_LOAD: begin
          a_q   <= '0;
          q_q   <= mag(dvd_q, mode_q);
          m_q   <= mag(dvs_q, mode_q);
          cnt_q <= CNT_W'(WIDTH);
          res_q <= '0;
          // Divide by zero resolves here: all-ones quotient, raw dividend back.
          if (dvs_q == '0) begin
            res_q.quo <= '1;
            res_q.rem <= dvd_q;
            res_q.dbz <= 1'b1;
          end
        end
        S_ITER: begin
          a_q   <= a_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          res_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = res_q.quo;
  assign bus.remainder   = res_q.rem;
  assign bus.div_by_zero = res_q.dbz;
  assign bus.overflow    = res_q.ovf;

endmodule
